auto_req_arb: RTL and testbench

- Credit-based scheduler that shares one auto_intf request channel (req_val/req_data/req_credit) among NREQ requesters.
- Routes the auto_intf response channel (rsp_cmd/rsp_data) back to the originating requester in issue order and returns rsp_credit.
- Sits between requester agents and the auto_i modport assignments. Owns credit accounting and the outstanding-order FIFO.

---
 rtl/auto_req_arb.sv | 172 +++++++++++++++++
 tb/tb_auto_req_arb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_req_arb.sv
// auto_req_arb: credit-based round-robin scheduler sharing one auto_intf
// request channel among NREQ requesters, with in-order response routing.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_i_val/req_i_data      per-requester request valid and 64-bit payload
//   req_i_gnt                 one-hot grant (combinational, accept cycle)
//   req_val/req_data          registered request beat towards auto_i
//   req_credit                one-cycle request credit return pulse
//   rsp_cmd/rsp_data          response beat from auto_i (00 idle, 01 data,
//                             10 data-last, 11 error-last)
//   rsp_credit                registered response credit pulse per beat
//   rsp_o_val/cmd/data        registered response routed to owning requester
//   credit_cnt                current request credits
//   err_credit_ovf            sticky: credit returned while count is full
//   err_rsp_unexp             sticky: response beat with no outstanding req
module auto_req_arb #(
    parameter int NREQ    = 4,
    parameter int CREDITS = 8,
    parameter int MAX_OUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_i_val,
    input  logic [NREQ*64-1:0] req_i_data,
    output logic [NREQ-1:0]    req_i_gnt,
    output logic               req_val,
    output logic [63:0]        req_data,
    input  logic               req_credit,
    input  logic [1:0]         rsp_cmd,
    input  logic [63:0]        rsp_data,
    output logic               rsp_credit,
    output logic [NREQ-1:0]    rsp_o_val,
    output logic [1:0]         rsp_o_cmd,
    output logic [63:0]        rsp_o_data,
    output logic [3:0]         credit_cnt,
    output logic               err_credit_ovf,
    output logic               err_rsp_unexp
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = AW + 1;

    logic [IW-1:0]   rr_q, rr_d;
    logic [3:0]      credit_q, credit_d;
    logic [IW-1:0]   fifo_q [MAX_OUT];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_val_q;
    logic [63:0]     req_data_q;
    logic            rsp_credit_q;
    logic [NREQ-1:0] rsp_o_val_q;
    logic [1:0]      rsp_o_cmd_q;
    logic [63:0]     rsp_o_data_q;
    logic            ovf_q, unexp_q;

    logic            accept_ok_s;
    logic            gnt_vld_s;
    logic [IW-1:0]   gnt_idx_s;
    logic [NREQ-1:0] gnt_s;
    logic            hit_s;
    logic [IW-1:0]   cand_s;
    logic            fwd_s, pop_s, unexp_s, ovf_set_s;
    logic [IW-1:0]   head_s;

    // Round-robin search from rr_q; reset gates the grant so nothing is accepted while held.
    always_comb begin
        accept_ok_s = (credit_q != 4'd0) && (cnt_q != CW'(MAX_OUT)) && !rst;
        gnt_vld_s   = 1'b0;
        gnt_idx_s   = '0;
        hit_s       = 1'b0;
        cand_s      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s    = IW'((int'(rr_q) + i) % NREQ);
            hit_s     = accept_ok_s && !gnt_vld_s && req_i_val[cand_s];
            gnt_idx_s = hit_s ? cand_s : gnt_idx_s;
            gnt_vld_s = gnt_vld_s | hit_s;
        end
        if (gnt_vld_s) begin
            gnt_s = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_s;
            rr_d  = IW'((int'(gnt_idx_s) + 1) % NREQ);
        end else begin
            gnt_s = '0;
            rr_d  = rr_q;
        end
    end

    // Response routing: the head is read from registered state, so a pop lands before the next beat.
    always_comb begin
        head_s  = fifo_q[rd_q];
        fwd_s   = (rsp_cmd != 2'b00) && (cnt_q != '0);
        unexp_s = (rsp_cmd != 2'b00) && (cnt_q == '0);
        pop_s   = fwd_s && rsp_cmd[1];
        case ({gnt_vld_s, pop_s})
            2'b10:   cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            default: cnt_d = cnt_q;
        endcase
    end

    // Credit accounting: grant consumes, req_credit returns, saturate at CREDITS.
    always_comb begin
        ovf_set_s = 1'b0;
        case ({gnt_vld_s, req_credit})
            2'b10:   credit_d = credit_q - 4'd1;
            2'b01: begin
                if (credit_q == 4'(CREDITS)) begin
                    credit_d  = credit_q;
                    ovf_set_s = 1'b1;
                end else begin
                    credit_d  = credit_q + 4'd1;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q         <= '0;
            credit_q     <= 4'(CREDITS);
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            req_val_q    <= 1'b0;
            req_data_q   <= 64'd0;
            rsp_credit_q <= 1'b0;
            rsp_o_val_q  <= '0;
            rsp_o_cmd_q  <= 2'b00;
            rsp_o_data_q <= 64'd0;
            ovf_q        <= 1'b0;
            unexp_q      <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            credit_q     <= credit_d;
            cnt_q        <= cnt_d;
            wr_q         <= gnt_vld_s ? wr_q + {{(AW-1){1'b0}}, 1'b1} : wr_q;
            rd_q         <= pop_s ? rd_q + {{(AW-1){1'b0}}, 1'b1} : rd_q;
            req_val_q    <= gnt_vld_s;
            req_data_q   <= gnt_vld_s ? req_i_data[int'(gnt_idx_s)*64 +: 64] : req_data_q;
            rsp_credit_q <= fwd_s;
            rsp_o_val_q  <= fwd_s ? ({{(NREQ-1){1'b0}}, 1'b1} << head_s) : '0;
            rsp_o_cmd_q  <= rsp_cmd;
            rsp_o_data_q <= rsp_data;
            ovf_q        <= ovf_q | ovf_set_s;
            unexp_q      <= unexp_q | unexp_s;
        end
    end

    // Order FIFO storage; validity is tracked by cnt_q, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (gnt_vld_s) begin
            fifo_q[wr_q] <= gnt_idx_s;
        end else begin
            fifo_q[wr_q] <= fifo_q[wr_q];
        end
    end

    assign req_i_gnt      = gnt_s;
    assign req_val        = req_val_q;
    assign req_data       = req_data_q;
    assign rsp_credit     = rsp_credit_q;
    assign rsp_o_val      = rsp_o_val_q;
    assign rsp_o_cmd      = rsp_o_cmd_q;
    assign rsp_o_data     = rsp_o_data_q;
    assign credit_cnt     = credit_q;
    assign err_credit_ovf = ovf_q;
    assign err_rsp_unexp  = unexp_q;

endmodule

// File: tb/tb_auto_req_arb.sv
module tb_auto_req_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_i_val;
    logic [255:0] req_i_data;
    logic [3:0]   req_i_gnt;
    logic         req_val;
    logic [63:0]  req_data;
    logic         req_credit;
    logic [1:0]   rsp_cmd;
    logic [63:0]  rsp_data;
    logic         rsp_credit;
    logic [3:0]   rsp_o_val;
    logic [1:0]   rsp_o_cmd;
    logic [63:0]  rsp_o_data;
    logic [3:0]   credit_cnt;
    logic         err_credit_ovf;
    logic         err_rsp_unexp;

    int checks = 0;
    int errors = 0;

    auto_req_arb #(.NREQ(4), .CREDITS(8), .MAX_OUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_i_val(req_i_val), .req_i_data(req_i_data), .req_i_gnt(req_i_gnt),
        .req_val(req_val), .req_data(req_data), .req_credit(req_credit),
        .rsp_cmd(rsp_cmd), .rsp_data(rsp_data), .rsp_credit(rsp_credit),
        .rsp_o_val(rsp_o_val), .rsp_o_cmd(rsp_o_cmd), .rsp_o_data(rsp_o_data),
        .credit_cnt(credit_cnt), .err_credit_ovf(err_credit_ovf),
        .err_rsp_unexp(err_rsp_unexp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic       c;
        logic [1:0] cmd;
        logic [7:0] d;
        logic [3:0] gnt;
        logic       rv;
        int         src;
        logic [3:0] cnt;
        logic [3:0] ov;
        logic       rc;
        logic       eu;
    } vec_t;

    vec_t tab[$];

    function automatic logic [63:0] pay(input int k);
        return 64'hC0DE_0000_0000_0000 + 64'(k);
    endfunction

    function automatic logic [63:0] rdat(input logic [7:0] d);
        return 64'h5A5A_0000_0000_0000 + {56'd0, d};
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic c, input logic [1:0] cmd,
                                input logic [7:0] d, input logic [3:0] gnt, input logic rv,
                                input int src, input logic [3:0] cnt, input logic [3:0] ov,
                                input logic rc, input logic eu);
        vec_t r;
        r.v = v; r.c = c; r.cmd = cmd; r.d = d; r.gnt = gnt; r.rv = rv;
        r.src = src; r.cnt = cnt; r.ov = ov; r.rc = rc; r.eu = eu;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic c, input logic [1:0] cmd,
                         input logic [63:0] d);
        @(negedge clk);
        req_i_val  = v;
        req_credit = c;
        rsp_cmd    = cmd;
        rsp_data   = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".req_val"}, {63'd0, req_val}, 64'd0);
        chk({tag, ".req_data"}, req_data, 64'd0);
        chk({tag, ".gnt"}, {60'd0, req_i_gnt}, 64'd0);
        chk({tag, ".rsp_credit"}, {63'd0, rsp_credit}, 64'd0);
        chk({tag, ".rsp_o_val"}, {60'd0, rsp_o_val}, 64'd0);
        chk({tag, ".rsp_o_cmd"}, {62'd0, rsp_o_cmd}, 64'd0);
        chk({tag, ".rsp_o_data"}, rsp_o_data, 64'd0);
        chk({tag, ".credit_cnt"}, {60'd0, credit_cnt}, 64'd8);
        chk({tag, ".err_ovf"}, {63'd0, err_credit_ovf}, 64'd0);
        chk({tag, ".err_unexp"}, {63'd0, err_rsp_unexp}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_i_val = 4'b0000; req_credit = 1'b0; rsp_cmd = 2'b00; rsp_data = 64'd0;
        #1;
        chk_reset_outs("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_i_val  = 4'b0000;
        req_credit = 1'b0;
        rsp_cmd    = 2'b00;
        rsp_data   = 64'd0;
        for (int k = 0; k < 4; k++) req_i_data[k*64 +: 64] = pay(k);

        // Burst of 8 round-robin grants until credits and FIFO are exhausted
        tab.push_back(mk(4'b1111, 1'b0, 2'b00, 8'h00, 4'b0001, 1'b1, 0, 4'd7, 4'b0000, 1'b0, 1'b0));
        tab.push_back(mk(4'b1111, 1'b0, 2'b00, 8'h00, 4'b0010, 1'b1, 1, 4'd6, 4'b0000, 1'b0, 1'b0));
        tab.push_back(mk(4'b1111, 1'b0, 2'b00, 8'h00, 4'b0100, 1'b1, 2, 4'd5, 4'b0000, 1'b0, 1'b0));
        tab.push_back(mk(4'b1111, 1'b0, 2'b00, 8'h00, 4'b1000, 1'b1, 3, 4'd4, 4'b0000, 1'b0, 1'b0));
        tab.push_back(mk(4'b1111, 1'b0, 2'b00, 8'h00, 4'b0001, 1'b1, 0, 4'd3, 4'b0000, 1'b0, 1'b0));
        tab.push_back(mk(4'b1111, 1'b0, 2'b00, 8'h00, 4'b0010, 1'b1, 1, 4'd2, 4'b0000, 1'b0, 1'b0));
        tab.push_back(mk(4'b1111, 1'b0, 2'b00, 8'h00, 4'b0100, 1'b1, 2, 4'd1, 4'b0000, 1'b0, 1'b0));
        tab.push_back(mk(4'b1111, 1'b0, 2'b00, 8'h00, 4'b1000, 1'b1, 3, 4'd0, 4'b0000, 1'b0, 1'b0));
        tab.push_back(mk(4'b1111, 1'b0, 2'b00, 8'h00, 4'b0000, 1'b0, 3, 4'd0, 4'b0000, 1'b0, 1'b0));
        // Credit returned with a last beat (pop head 0); grant to 2 only on the next cycle
        tab.push_back(mk(4'b0100, 1'b1, 2'b10, 8'h55, 4'b0000, 1'b0, 3, 4'd1, 4'b0001, 1'b1, 1'b0));
        tab.push_back(mk(4'b0100, 1'b0, 2'b00, 8'h00, 4'b0100, 1'b1, 2, 4'd0, 4'b0000, 1'b0, 1'b0));
        // Non-last beat keeps the head; last beats advance through heads 1,2,3
        tab.push_back(mk(4'b0000, 1'b0, 2'b01, 8'h11, 4'b0000, 1'b0, 2, 4'd0, 4'b0010, 1'b1, 1'b0));
        tab.push_back(mk(4'b0000, 1'b0, 2'b11, 8'h22, 4'b0000, 1'b0, 2, 4'd0, 4'b0010, 1'b1, 1'b0));
        tab.push_back(mk(4'b0000, 1'b0, 2'b10, 8'h33, 4'b0000, 1'b0, 2, 4'd0, 4'b0100, 1'b1, 1'b0));
        tab.push_back(mk(4'b0000, 1'b0, 2'b10, 8'h44, 4'b0000, 1'b0, 2, 4'd0, 4'b1000, 1'b1, 1'b0));
        // Refill credits to 5
        for (int n = 1; n <= 5; n++)
            tab.push_back(mk(4'b0000, 1'b1, 2'b00, 8'h00, 4'b0000, 1'b0, 2, 4'(n), 4'b0000, 1'b0, 1'b0));
        // Grant to 1 coincides with a credit return: count stays 5
        tab.push_back(mk(4'b0010, 1'b1, 2'b00, 8'h00, 4'b0010, 1'b1, 1, 4'd5, 4'b0000, 1'b0, 1'b0));
        // Drain remaining order 0,1,2,3,2,1
        tab.push_back(mk(4'b0000, 1'b0, 2'b10, 8'h61, 4'b0000, 1'b0, 1, 4'd5, 4'b0001, 1'b1, 1'b0));
        tab.push_back(mk(4'b0000, 1'b0, 2'b10, 8'h62, 4'b0000, 1'b0, 1, 4'd5, 4'b0010, 1'b1, 1'b0));
        tab.push_back(mk(4'b0000, 1'b0, 2'b11, 8'h63, 4'b0000, 1'b0, 1, 4'd5, 4'b0100, 1'b1, 1'b0));
        tab.push_back(mk(4'b0000, 1'b0, 2'b10, 8'h64, 4'b0000, 1'b0, 1, 4'd5, 4'b1000, 1'b1, 1'b0));
        tab.push_back(mk(4'b0000, 1'b0, 2'b10, 8'h65, 4'b0000, 1'b0, 1, 4'd5, 4'b0100, 1'b1, 1'b0));
        tab.push_back(mk(4'b0000, 1'b0, 2'b10, 8'h66, 4'b0000, 1'b0, 1, 4'd5, 4'b0010, 1'b1, 1'b0));
        // Response with FIFO empty is dropped and flagged
        tab.push_back(mk(4'b0000, 1'b0, 2'b01, 8'h77, 4'b0000, 1'b0, 1, 4'd5, 4'b0000, 1'b0, 1'b1));
        tab.push_back(mk(4'b0000, 1'b0, 2'b00, 8'h00, 4'b0000, 1'b0, 1, 4'd5, 4'b0000, 1'b0, 1'b1));

        // Power-on reset state
        #1;
        chk_reset_outs("por");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tab.size(); i++) begin
            drive(tab[i].v, tab[i].c, tab[i].cmd, rdat(tab[i].d));
            chk($sformatf("v%0d.gnt", i), {60'd0, req_i_gnt}, {60'd0, tab[i].gnt});
            tick();
            chk($sformatf("v%0d.req_val", i), {63'd0, req_val}, {63'd0, tab[i].rv});
            chk($sformatf("v%0d.req_data", i), req_data, pay(tab[i].src));
            chk($sformatf("v%0d.credit_cnt", i), {60'd0, credit_cnt}, {60'd0, tab[i].cnt});
            chk($sformatf("v%0d.rsp_o_val", i), {60'd0, rsp_o_val}, {60'd0, tab[i].ov});
            chk($sformatf("v%0d.rsp_credit", i), {63'd0, rsp_credit}, {63'd0, tab[i].rc});
            chk($sformatf("v%0d.err_unexp", i), {63'd0, err_rsp_unexp}, {63'd0, tab[i].eu});
            chk($sformatf("v%0d.err_ovf", i), {63'd0, err_credit_ovf}, 64'd0);
            if (tab[i].ov != 4'b0000) begin
                chk($sformatf("v%0d.rsp_o_data", i), rsp_o_data, rdat(tab[i].d));
                chk($sformatf("v%0d.rsp_o_cmd", i), {62'd0, rsp_o_cmd}, {62'd0, tab[i].cmd});
            end
        end

        // Issue to 3 then 0, then responses 01/10/11 with data A,B,C
        do_reset();
        drive(4'b1000, 1'b0, 2'b00, 64'd0);
        chk("seq.gnt3", {60'd0, req_i_gnt}, 64'h8);
        tick();
        chk("seq.issue3", req_data, pay(3));
        drive(4'b0001, 1'b0, 2'b00, 64'd0);
        chk("seq.gnt0", {60'd0, req_i_gnt}, 64'h1);
        tick();
        chk("seq.issue0", req_data, pay(0));
        chk("seq.cnt6", {60'd0, credit_cnt}, 64'd6);
        drive(4'b0000, 1'b0, 2'b01, 64'hAAAA_AAAA_AAAA_AAAA);
        tick();
        chk("seq.A.val", {60'd0, rsp_o_val}, 64'h8);
        chk("seq.A.data", rsp_o_data, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("seq.A.credit", {63'd0, rsp_credit}, 64'd1);
        drive(4'b0000, 1'b0, 2'b10, 64'hBBBB_BBBB_BBBB_BBBB);
        tick();
        chk("seq.B.val", {60'd0, rsp_o_val}, 64'h8);
        chk("seq.B.data", rsp_o_data, 64'hBBBB_BBBB_BBBB_BBBB);
        chk("seq.B.credit", {63'd0, rsp_credit}, 64'd1);
        drive(4'b0000, 1'b0, 2'b11, 64'hCCCC_CCCC_CCCC_CCCC);
        tick();
        chk("seq.C.val", {60'd0, rsp_o_val}, 64'h1);
        chk("seq.C.data", rsp_o_data, 64'hCCCC_CCCC_CCCC_CCCC);
        chk("seq.C.cmd", {62'd0, rsp_o_cmd}, 64'd3);
        chk("seq.C.credit", {63'd0, rsp_credit}, 64'd1);
        drive(4'b0000, 1'b0, 2'b01, 64'hDDDD_DDDD_DDDD_DDDD);
        tick();
        chk("seq.unexp.val", {60'd0, rsp_o_val}, 64'd0);
        chk("seq.unexp.credit", {63'd0, rsp_credit}, 64'd0);
        chk("seq.unexp.flag", {63'd0, err_rsp_unexp}, 64'd1);
        drive(4'b0000, 1'b0, 2'b00, 64'd0);
        tick();
        chk("seq.unexp.sticky", {63'd0, err_rsp_unexp}, 64'd1);

        // Credit overflow at full count
        drive(4'b0000, 1'b1, 2'b00, 64'd0);
        tick();
        chk("ovf.cnt7", {60'd0, credit_cnt}, 64'd7);
        tick();
        chk("ovf.cnt8", {60'd0, credit_cnt}, 64'd8);
        chk("ovf.flag_clear", {63'd0, err_credit_ovf}, 64'd0);
        tick();
        chk("ovf.cnt_sat", {60'd0, credit_cnt}, 64'd8);
        chk("ovf.flag", {63'd0, err_credit_ovf}, 64'd1);
        drive(4'b0000, 1'b0, 2'b00, 64'd0);
        tick();
        chk("ovf.sticky", {63'd0, err_credit_ovf}, 64'd1);

        // Reset mid-burst with 3 outstanding
        do_reset();
        drive(4'b1111, 1'b0, 2'b00, 64'd0);
        tick(); tick(); tick();
        chk("mid.cnt5", {60'd0, credit_cnt}, 64'd5);
        chk("mid.req_val", {63'd0, req_val}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outs("mid");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post.gnt0", {60'd0, req_i_gnt}, 64'h1);
        tick();
        chk("post.req_val", {63'd0, req_val}, 64'd1);
        chk("post.req_data", req_data, pay(0));
        chk("post.cnt", {60'd0, credit_cnt}, 64'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
